// File: rtl/point_readout_scheduler.sv
// Per-frame readout controller: triggers the centroid merge, snapshots the finder
// results and streams them as a framed, XOR-checksummed byte packet.
`timescale 1ns/1ps
module point_readout_scheduler #(
  parameter int MAX_POINTS = 4,
  parameter int FRAME_DIV  = 1,
  parameter int TIMEOUT    = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        VGA_VS,
  input  logic        ENABLE,
  input  logic        MERGE_DONE,
  input  logic [2:0]  POINT_COUNT,
  input  logic [63:0] POINTS_H,
  input  logic [63:0] POINTS_V,
  output logic        MERGE_START,
  output logic [7:0]  o_DATA,
  output logic        o_VALID,
  input  logic        i_READY,
  output logic [15:0] o_FRAME_ID,
  output logic [15:0] o_DROP_CNT,
  output logic        o_BUSY
);

  typedef enum logic [1:0] {IDLE, WAIT_MERGE, LATCH, SEND} state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int DW = $clog2(FRAME_DIV + 1);
  localparam logic [2:0] MAX_N = 3'(MAX_POINTS);

  state_t        state;
  logic          vs_q;
  logic [DW-1:0] dec_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [2:0]    n;
  logic [63:0]   pts_h;
  logic [63:0]   pts_v;
  logic [4:0]    idx;
  logic [7:0]    chk;

  logic          vs_fall;
  logic          xfer;
  logic          tmo_hit;
  logic [4:0]    nidx;
  logic [4:0]    last_idx;
  logic [3:0]    body;
  logic [15:0]   h_word;
  logic [15:0]   v_word;
  logic [7:0]    chk_next;
  logic [7:0]    next_byte;
  logic [1:0]    drop_inc;
  logic [16:0]   drop_sum;

  assign vs_fall  = vs_q & ~VGA_VS;
  assign xfer     = o_VALID & i_READY;
  assign tmo_hit  = (state == WAIT_MERGE) && !MERGE_DONE && (tmo_cnt == TW'(TIMEOUT - 1));
  assign nidx     = idx + 5'd1;
  assign last_idx = 5'd3 + {n, 2'b00};
  // The 0xA5 sync byte is excluded from the checksum.
  assign chk_next = (idx == 5'd0) ? chk : (chk ^ o_DATA);
  assign body     = 4'(nidx - 5'd3);
  assign h_word   = pts_h[{body[3:2], 4'b0000} +: 16];
  assign v_word   = pts_v[{body[3:2], 4'b0000} +: 16];
  assign drop_inc = {1'b0, vs_fall && (state != IDLE)} + {1'b0, tmo_hit};
  assign drop_sum = {1'b0, o_DROP_CNT} + {15'b0, drop_inc};
  assign o_BUSY   = (state != IDLE);

  // NOTE: next_byte gets a value before any branch so no path leaves it unassigned
  // (an unassigned path would infer a latch).
  always_comb begin
    next_byte = chk_next;
    if (nidx == 5'd1) begin
      next_byte = o_FRAME_ID[7:0];
    end else if (nidx == 5'd2) begin
      next_byte = {5'b00000, n};
    end else if (nidx != last_idx) begin
      case (body[1:0])
        2'd0:    next_byte = h_word[15:8];
        2'd1:    next_byte = h_word[7:0];
        2'd2:    next_byte = v_word[15:8];
        default: next_byte = v_word[7:0];
      endcase
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      vs_q        <= 1'b0;
      dec_cnt     <= '0;
      tmo_cnt     <= '0;
      n           <= '0;
      pts_h       <= '0;
      pts_v       <= '0;
      idx         <= '0;
      chk         <= '0;
      MERGE_START <= 1'b0;
      o_DATA      <= '0;
      o_VALID     <= 1'b0;
      o_FRAME_ID  <= '0;
      o_DROP_CNT  <= '0;
    end else begin
      vs_q        <= VGA_VS;
      MERGE_START <= 1'b0;
      o_DROP_CNT  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      case (state)
        IDLE: begin
          if (vs_fall && ENABLE) begin
            dec_cnt <= (dec_cnt == DW'(FRAME_DIV - 1)) ? '0 : dec_cnt + DW'(1);
            if (dec_cnt == '0) begin
              MERGE_START <= 1'b1;
              tmo_cnt     <= '0;
              state       <= WAIT_MERGE;
            end
          end
        end
        WAIT_MERGE: begin
          if (MERGE_DONE)   state   <= LATCH;
          else if (tmo_hit) state   <= IDLE;
          else              tmo_cnt <= tmo_cnt + TW'(1);
        end
        LATCH: begin
          n       <= (POINT_COUNT > MAX_N) ? MAX_N : POINT_COUNT;
          pts_h   <= POINTS_H;
          pts_v   <= POINTS_V;
          chk     <= '0;
          idx     <= '0;
          o_DATA  <= 8'hA5;
          o_VALID <= 1'b1;
          state   <= SEND;
        end
        default: begin
          if (xfer) begin
            if (idx == last_idx) begin
              o_VALID    <= 1'b0;
              o_FRAME_ID <= o_FRAME_ID + 16'd1;
              state      <= IDLE;
            end else begin
              idx    <= nidx;
              chk    <= chk_next;
              o_DATA <= next_byte;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_point_readout_scheduler.sv
// Randomized self-checking bench: packets are rebuilt from the frame inputs by a
// byte-list model and compared with what the stream actually delivered.
`timescale 1ns/1ps
module tb_point_readout_scheduler;

  localparam int RDY_ON = 0, RDY_TOGGLE = 1, RDY_RAND = 2, RDY_OFF = 3;

  typedef logic [7:0] byte_q_t[$];

  logic        CLK = 1'b0;
  logic        RST, VGA_VS, ENABLE, MERGE_DONE, i_READY;
  logic [2:0]  POINT_COUNT;
  logic [63:0] POINTS_H, POINTS_V;
  logic        ms_a, valid_a, busy_a, ms_b, valid_b, busy_b;
  logic [7:0]  data_a, data_b;
  logic [15:0] fid_a, drop_a, fid_b, drop_b;

  int checks = 0, errors = 0;
  int ready_mode = RDY_ON, tog_cnt = 0;
  int valid_cnt_a = 0, unstable_a = 0, unstable_b = 0;
  logic stall_a = 1'b0, stall_b = 1'b0;
  logic [7:0] prev_a = 8'h00, prev_b = 8'h00;
  byte_q_t qa, qb;
  int fid_a_model = 0, fid_b_model = 0;

  always #5 CLK = ~CLK;

  point_readout_scheduler #(.MAX_POINTS(4), .FRAME_DIV(1), .TIMEOUT(16)) dut_a (
    .CLK(CLK), .RST(RST), .VGA_VS(VGA_VS), .ENABLE(ENABLE), .MERGE_DONE(MERGE_DONE),
    .POINT_COUNT(POINT_COUNT), .POINTS_H(POINTS_H), .POINTS_V(POINTS_V),
    .MERGE_START(ms_a), .o_DATA(data_a), .o_VALID(valid_a), .i_READY(i_READY),
    .o_FRAME_ID(fid_a), .o_DROP_CNT(drop_a), .o_BUSY(busy_a));

  point_readout_scheduler #(.MAX_POINTS(2), .FRAME_DIV(3), .TIMEOUT(16)) dut_b (
    .CLK(CLK), .RST(RST), .VGA_VS(VGA_VS), .ENABLE(ENABLE), .MERGE_DONE(MERGE_DONE),
    .POINT_COUNT(POINT_COUNT), .POINTS_H(POINTS_H), .POINTS_V(POINTS_V),
    .MERGE_START(ms_b), .o_DATA(data_b), .o_VALID(valid_b), .i_READY(i_READY),
    .o_FRAME_ID(fid_b), .o_DROP_CNT(drop_b), .o_BUSY(busy_b));

  // Stream monitor, sampled mid-cycle.
  always @(negedge CLK) begin
    if (valid_a) valid_cnt_a++;
    if (stall_a && valid_a && data_a !== prev_a) unstable_a++;
    if (stall_b && valid_b && data_b !== prev_b) unstable_b++;
    stall_a = valid_a && !i_READY;
    stall_b = valid_b && !i_READY;
    prev_a  = data_a;
    prev_b  = data_b;
    if (valid_a && i_READY) qa.push_back(data_a);
    if (valid_b && i_READY) qb.push_back(data_b);
  end

  // Packet built straight from the byte-layout rules.
  function automatic byte_q_t model_packet(int fid, int pc, logic [63:0] h, logic [63:0] v, int maxp);
    byte_q_t q;
    int n;
    logic [7:0]  c;
    logic [15:0] hw, vw;
    n = (pc < maxp) ? pc : maxp;
    q.push_back(8'hA5);
    q.push_back(fid[7:0]);
    q.push_back(8'(n));
    for (int k = 0; k < n; k++) begin
      hw = h[16*k +: 16];
      vw = v[16*k +: 16];
      q.push_back(hw[15:8]); q.push_back(hw[7:0]);
      q.push_back(vw[15:8]); q.push_back(vw[7:0]);
    end
    c = 8'h00;
    for (int i = 1; i < q.size(); i++) c ^= q[i];
    q.push_back(c);
    return q;
  endfunction

  function automatic int first_diff(byte_q_t got, byte_q_t exp);
    int m;
    m = (got.size() < exp.size()) ? got.size() : exp.size();
    for (int i = 0; i < m; i++) if (got[i] !== exp[i]) return i;
    return (got.size() == exp.size()) ? -1 : m;
  endfunction

  function automatic logic [7:0] q_at(byte_q_t q, int i);
    return (i < q.size()) ? q[i] : 8'hxx;
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
    case (ready_mode)
      RDY_ON:   i_READY = 1'b1;
      RDY_OFF:  i_READY = 1'b0;
      RDY_RAND: i_READY = 1'($urandom_range(0, 1));
      default: begin
        if (valid_a) begin
          i_READY = (tog_cnt % 2 == 0);
          tog_cnt++;
        end else begin
          i_READY = 1'b1;
        end
      end
    endcase
  endtask

  task automatic vs_edge();
    VGA_VS = 1'b1; step();
    VGA_VS = 1'b0; step();
    VGA_VS = 1'b1;
  endtask

  // Runs one frame; finder inputs are scrambled (and ENABLE dropped) during SEND if asked.
  task automatic run_frame(input logic [2:0] pc, input logic [63:0] h, input logic [63:0] v,
                           input int mode, input int dly, input bit scramble,
                           output bit ms_seen_a, output bit ms_seen_b, output bit hung);
    ENABLE = 1'b1; POINT_COUNT = pc; POINTS_H = h; POINTS_V = v; MERGE_DONE = 1'b0;
    ready_mode = mode; tog_cnt = 0;
    qa.delete(); qb.delete();
    valid_cnt_a = 0; unstable_a = 0; unstable_b = 0;
    vs_edge();
    ms_seen_a = ms_a;
    ms_seen_b = ms_b;
    repeat (dly) step();
    MERGE_DONE = 1'b1; step(); MERGE_DONE = 1'b0;
    hung = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (!busy_a && !busy_b) begin hung = 1'b0; break; end
      if (scramble && valid_a) begin
        POINT_COUNT = 3'($urandom); POINTS_H = {$urandom, $urandom}; POINTS_V = {$urandom, $urandom};
        ENABLE = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; VGA_VS = 1'b1; ENABLE = 1'b1; MERGE_DONE = 1'b0; i_READY = 1'b1;
    POINT_COUNT = '0; POINTS_H = '0; POINTS_V = '0;
    step(); step();
    checks++; if ({ms_a, valid_a, busy_a, data_a} !== 11'd0) begin
      errors++; $display("FAIL reset_ctrl: ms/valid/busy/data=%b/%b/%b/%h expected all 0", ms_a, valid_a, busy_a, data_a);
    end
    checks++; if (fid_a !== 16'd0 || drop_a !== 16'd0) begin
      errors++; $display("FAIL reset_counters: frame_id=%0d drop=%0d expected 0/0", fid_a, drop_a);
    end
    RST = 1'b0; step();
  endtask

  task automatic test_single_frame();
    byte_q_t exp; bit ma, mb, hung; int d;
    exp = model_packet(fid_a_model, 2, 64'h0000_0000_0200_0123, 64'h0000_0000_0010_0045, 4);
    run_frame(3'd2, 64'h0000_0000_0200_0123, 64'h0000_0000_0010_0045, RDY_ON, 3, 1'b0, ma, mb, hung);
    fid_a_model++;
    checks++; if (ma !== 1'b1 || hung) begin errors++; $display("FAIL single_start: merge_start=%b hung=%b expected 1/0", ma, hung); end
    d = first_diff(qa, exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL single_pkt: byte %0d got %h expected %h (len %0d vs %0d)", d, q_at(qa, d), q_at(exp, d), qa.size(), exp.size()); end
    checks++; if (q_at(qa, 11) !== 8'h77) begin errors++; $display("FAIL single_chk: got %h expected 77", q_at(qa, 11)); end
    checks++; if (valid_cnt_a != 12) begin errors++; $display("FAIL single_valid_cycles: got %0d expected 12", valid_cnt_a); end
    checks++; if (fid_a !== 16'(fid_a_model)) begin errors++; $display("FAIL single_frame_id: got %0d expected %0d", fid_a, fid_a_model); end
  endtask

  task automatic test_stall();
    byte_q_t exp; bit ma, mb, hung; int d;
    exp = model_packet(fid_a_model, 2, 64'h0000_0000_0200_0123, 64'h0000_0000_0010_0045, 4);
    run_frame(3'd2, 64'h0000_0000_0200_0123, 64'h0000_0000_0010_0045, RDY_TOGGLE, 3, 1'b0, ma, mb, hung);
    fid_a_model++;
    d = first_diff(qa, exp);
    checks++; if (d >= 0 || hung) begin errors++; $display("FAIL stall_pkt: byte %0d got %h expected %h hung=%b", d, q_at(qa, d), q_at(exp, d), hung); end
    checks++; if (valid_cnt_a != 23) begin errors++; $display("FAIL stall_send_cycles: got %0d expected 23", valid_cnt_a); end
    checks++; if (unstable_a != 0) begin errors++; $display("FAIL stall_data_stable: %0d changes during stall, expected 0", unstable_a); end
  endtask

  task automatic test_clamp();
    byte_q_t exp; bit ma, mb, hung; int d;
    logic [63:0] h, v;
    h = {$urandom, $urandom}; v = {$urandom, $urandom};
    exp = model_packet(fid_a_model, 7, h, v, 4);
    run_frame(3'd7, h, v, RDY_ON, 1, 1'b0, ma, mb, hung);
    fid_a_model++;
    checks++; if (qa.size() != 20 || q_at(qa, 2) !== 8'h04) begin errors++; $display("FAIL clamp_len: len %0d count %h expected 20/04", qa.size(), q_at(qa, 2)); end
    d = first_diff(qa, exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL clamp_pkt: byte %0d got %h expected %h", d, q_at(qa, d), q_at(exp, d)); end
    exp = model_packet(fid_a_model, 0, h, v, 4);
    run_frame(3'd0, h, v, RDY_ON, 0, 1'b0, ma, mb, hung);
    checks++; if (qa.size() != 4 || q_at(qa, 3) !== 8'(fid_a_model)) begin
      errors++; $display("FAIL empty_pkt: len %0d chk %h expected 4/%h", qa.size(), q_at(qa, 3), 8'(fid_a_model));
    end
    fid_a_model++;
    d = first_diff(qa, exp);
    checks++; if (d >= 0) begin errors++; $display("FAIL empty_bytes: byte %0d got %h expected %h", d, q_at(qa, d), q_at(exp, d)); end
  endtask

  task automatic test_timeout();
    int k; logic [15:0] drop0;
    drop0 = drop_a; valid_cnt_a = 0; ENABLE = 1'b1; MERGE_DONE = 1'b0; ready_mode = RDY_ON;
    vs_edge();
    checks++; if (ms_a !== 1'b1) begin errors++; $display("FAIL timeout_start: merge_start=%b expected 1", ms_a); end
    k = 0;
    while (busy_a && k < 100) begin step(); k++; end
    checks++; if (k != 16) begin errors++; $display("FAIL timeout_cycles: idle after %0d cycles expected 16", k); end
    checks++; if (drop_a !== drop0 + 16'd1) begin errors++; $display("FAIL timeout_drop: got %0d expected %0d", drop_a, drop0 + 16'd1); end
    checks++; if (valid_cnt_a != 0 || fid_a !== 16'(fid_a_model)) begin
      errors++; $display("FAIL timeout_quiet: valid cycles %0d frame_id %0d expected 0/%0d", valid_cnt_a, fid_a, fid_a_model);
    end
    repeat (20) step();
  endtask

  task automatic test_vs_during_send();
    byte_q_t exp; int d, k; logic [15:0] drop0;
    logic [63:0] h, v;
    h = {$urandom, $urandom}; v = {$urandom, $urandom};
    exp = model_packet(fid_a_model, 3, h, v, 4);
    ENABLE = 1'b1; POINT_COUNT = 3'd3; POINTS_H = h; POINTS_V = v;
    ready_mode = RDY_OFF; qa.delete(); unstable_a = 0;
    vs_edge();
    step(); MERGE_DONE = 1'b1; step(); MERGE_DONE = 1'b0;
    k = 0;
    while (!valid_a && k < 50) begin step(); k++; end
    repeat (2) step();
    drop0 = drop_a;
    vs_edge();
    step();
    checks++; if (drop_a !== drop0 + 16'd1) begin errors++; $display("FAIL vs_send_drop: got %0d expected %0d", drop_a, drop0 + 16'd1); end
    checks++; if (valid_a !== 1'b1 || ms_a !== 1'b0) begin errors++; $display("FAIL vs_send_norestart: valid=%b merge_start=%b expected 1/0", valid_a, ms_a); end
    ready_mode = RDY_ON;
    k = 0;
    while ((busy_a || busy_b) && k < 200) begin step(); k++; end
    fid_a_model++;
    d = first_diff(qa, exp);
    checks++; if (d >= 0 || unstable_a != 0) begin
      errors++; $display("FAIL vs_send_pkt: byte %0d got %h expected %h unstable=%0d", d, q_at(qa, d), q_at(exp, d), unstable_a);
    end
  endtask

  task automatic test_random();
    byte_q_t exp; bit ma, mb, hung; int d, pc;
    logic [63:0] h, v;
    for (int i = 0; i < 8; i++) begin
      pc = $urandom_range(0, 7);
      h = {$urandom, $urandom}; v = {$urandom, $urandom};
      exp = model_packet(fid_a_model, pc, h, v, 4);
      run_frame(3'(pc), h, v, RDY_RAND, $urandom_range(0, 4), 1'b1, ma, mb, hung);
      fid_a_model++;
      d = first_diff(qa, exp);
      checks++; if (d >= 0 || hung || unstable_a != 0) begin
        errors++; $display("FAIL random_pkt[%0d]: byte %0d got %h expected %h hung=%b unstable=%0d", i, d, q_at(qa, d), q_at(exp, d), hung, unstable_a);
      end
    end
    checks++; if (fid_a !== 16'(fid_a_model)) begin errors++; $display("FAIL random_frame_id: got %0d expected %0d", fid_a, fid_a_model); end
  endtask

  task automatic test_enable_gating();
    logic [15:0] drop0;
    drop0 = drop_a; ENABLE = 1'b0;
    vs_edge();
    checks++; if (ms_a !== 1'b0 || busy_a !== 1'b0 || drop_a !== drop0) begin
      errors++; $display("FAIL enable_gate: merge_start=%b busy=%b drop=%0d expected 0/0/%0d", ms_a, busy_a, drop_a, drop0);
    end
    ENABLE = 1'b1;
  endtask

  task automatic test_decimation();
    byte_q_t exp; bit ma, mb, hung; int d, pc;
    logic [63:0] h, v;
    RST = 1'b1; step(); RST = 1'b0; step();
    fid_a_model = 0; fid_b_model = 0;
    for (int e = 0; e < 6; e++) begin
      pc = $urandom_range(0, 7);
      h = {$urandom, $urandom}; v = {$urandom, $urandom};
      exp = model_packet(fid_b_model, pc, h, v, 2);
      run_frame(3'(pc), h, v, RDY_ON, 2, 1'b0, ma, mb, hung);
      fid_a_model++;
      checks++; if (mb !== (e % 3 == 0) || hung) begin
        errors++; $display("FAIL decim_start[%0d]: merge_start=%b expected %b hung=%b", e, mb, (e % 3 == 0), hung);
      end
      if (e % 3 == 0) begin
        fid_b_model++;
        d = first_diff(qb, exp);
        checks++; if (d >= 0) begin errors++; $display("FAIL decim_pkt[%0d]: byte %0d got %h expected %h", e, d, q_at(qb, d), q_at(exp, d)); end
      end else begin
        checks++; if (qb.size() != 0) begin errors++; $display("FAIL decim_skip[%0d]: got %0d bytes expected 0", e, qb.size()); end
      end
    end
    checks++; if (fid_b !== 16'd2 || fid_a !== 16'd6 || drop_b !== 16'd0) begin
      errors++; $display("FAIL decim_counts: b_id=%0d a_id=%0d b_drop=%0d expected 2/6/0", fid_b, fid_a, drop_b);
    end
  endtask

  task automatic test_reset_mid_packet();
    byte_q_t exp; bit ma, mb, hung; int d, k;
    logic [63:0] h, v;
    h = {$urandom, $urandom}; v = {$urandom, $urandom};
    ENABLE = 1'b1; POINT_COUNT = 3'd4; POINTS_H = h; POINTS_V = v; ready_mode = RDY_ON; qa.delete();
    vs_edge();
    step(); MERGE_DONE = 1'b1; step(); MERGE_DONE = 1'b0;
    k = 0;
    while (qa.size() < 5 && k < 100) begin step(); k++; end
    RST = 1'b1; #1;
    checks++; if ({valid_a, busy_a, ms_a} !== 3'b000 || fid_a !== 16'd0 || drop_a !== 16'd0 || data_a !== 8'd0) begin
      errors++; $display("FAIL rst_mid: valid=%b busy=%b id=%0d drop=%0d data=%h expected all 0", valid_a, busy_a, fid_a, drop_a, data_a);
    end
    step(); RST = 1'b0; step();
    exp = model_packet(0, 4, h, v, 4);
    run_frame(3'd4, h, v, RDY_ON, 1, 1'b0, ma, mb, hung);
    d = first_diff(qa, exp);
    checks++; if (d >= 0 || hung) begin errors++; $display("FAIL rst_fresh_pkt: byte %0d got %h expected %h hung=%b", d, q_at(qa, d), q_at(exp, d), hung); end
    checks++; if (fid_a !== 16'd1) begin errors++; $display("FAIL rst_fresh_id: got %0d expected 1", fid_a); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_stall();
    test_clamp();
    test_timeout();
    test_vs_during_send();
    test_random();
    test_enable_gating();
    test_decimation();
    test_reset_mid_packet();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
